cellrv32_sysinfo_fetch: RTL and testbench



---
 rtl/cellrv32_sysinfo_fetch.sv | 153 +++++++++++++++
 tb/tb_cellrv32_sysinfo_fetch.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cellrv32_sysinfo_fetch.sv
// SYSINFO shadow fetcher: walks the read-only SYSINFO word block over the
// internal IO bus (one rden per word) and keeps a local copy of every word.
module cellrv32_sysinfo_fetch #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFFFFE0,
    parameter int          NUM_WORDS  = 8,
    parameter int          TIMEOUT    = 15,
    parameter logic        AUTO_START = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    start_i,
    output logic [31:0]             bus_addr_o,
    output logic                    bus_rden_o,
    output logic                    bus_wren_o,
    input  logic [31:0]             bus_data_i,
    input  logic                    bus_ack_i,
    input  logic                    bus_err_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    valid_o,
    output logic [1:0]              err_code_o,
    output logic [2:0]              err_idx_o,
    output logic [NUM_WORDS*32-1:0] info_o
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);
    localparam logic [7:0] TMO_CNT  = 8'(TIMEOUT);
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_BUS  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              idx_q;
    logic [7:0]              cnt_q;
    logic                    auto_q;
    logic                    done_q;
    logic                    valid_q;
    logic [1:0]              err_code_q;
    logic [2:0]              err_idx_q;
    logic [NUM_WORDS*32-1:0] info_q;

    logic launch;
    logic capture;
    logic last_word;
    logic abort_bus;
    logic abort_tmo;

    always_comb begin
        state_d    = state_q;
        launch     = 1'b0;
        capture    = 1'b0;
        abort_bus  = 1'b0;
        abort_tmo  = 1'b0;
        bus_rden_o = 1'b0;
        bus_addr_o = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (start_i || auto_q) begin
                    launch  = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                bus_rden_o = 1'b1;
                bus_addr_o = BASE_ADDR + {27'd0, idx_q, 2'b00};
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // error wins over an ack presented in the same cycle
                if (bus_err_i) begin
                    abort_bus = 1'b1;
                    state_d   = S_IDLE;
                end else if (bus_ack_i) begin
                    capture = 1'b1;
                    state_d = (idx_q == LAST_IDX) ? S_IDLE : S_REQ;
                end else if (cnt_q == TMO_CNT) begin
                    abort_tmo = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign last_word = capture && (idx_q == LAST_IDX);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            cnt_q      <= 8'd0;
            auto_q     <= AUTO_START;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            err_idx_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            auto_q  <= 1'b0;
            done_q  <= (state_q == S_WAIT) && (state_d == S_IDLE);
            if (launch) begin
                idx_q      <= 3'd0;
                valid_q    <= 1'b0;
                err_code_q <= ERR_NONE;
            end
            if (state_q == S_REQ) begin
                cnt_q <= 8'd0;
            end else if ((state_q == S_WAIT) && (state_d == S_WAIT)) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (last_word) begin
                valid_q <= 1'b1;
            end else if (capture) begin
                idx_q <= idx_q + 3'd1;
            end
            if (abort_bus) begin
                err_code_q <= ERR_BUS;
                err_idx_q  <= idx_q;
            end else if (abort_tmo) begin
                err_code_q <= ERR_TMO;
                err_idx_q  <= idx_q;
            end
        end
    end

    // shadow copy; an aborted fetch leaves uncaptured words untouched
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            info_q <= '0;
        end else begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (capture && (idx_q == 3'(k))) begin
                    info_q[k*32 +: 32] <= bus_data_i;
                end
            end
        end
    end

    assign bus_wren_o = 1'b0;
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;
    assign valid_o    = valid_q;
    assign err_code_o = err_code_q;
    assign err_idx_o  = err_idx_q;
    assign info_o     = info_q;

endmodule

// File: tb/tb_cellrv32_sysinfo_fetch.sv
// Bench for cellrv32_sysinfo_fetch: programmable-latency responder plus a
// timeline model of each fetch, compared against the DUT every cycle.
module tb_cellrv32_sysinfo_fetch;

    localparam logic [31:0] BASE = 32'hFFFFFFE0;
    localparam int NW   = 8;
    localparam int TMO  = 15;
    localparam int MAXC = 64;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic          start_i = 1'b0;
    logic [31:0]   bus_addr_o;
    logic          bus_rden_o;
    logic          bus_wren_o;
    logic [31:0]   bus_data_i = 32'd0;
    logic          bus_ack_i = 1'b0;
    logic          bus_err_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic          valid_o;
    logic [1:0]    err_code_o;
    logic [2:0]    err_idx_o;
    logic [NW*32-1:0] info_o;

    cellrv32_sysinfo_fetch #(
        .BASE_ADDR (BASE),
        .NUM_WORDS (NW),
        .TIMEOUT   (TMO),
        .AUTO_START(1'b1)
    ) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .start_i   (start_i),
        .bus_addr_o(bus_addr_o),
        .bus_rden_o(bus_rden_o),
        .bus_wren_o(bus_wren_o),
        .bus_data_i(bus_data_i),
        .bus_ack_i (bus_ack_i),
        .bus_err_i (bus_err_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .valid_o   (valid_o),
        .err_code_o(err_code_o),
        .err_idx_o (err_idx_o),
        .info_o    (info_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] expv, input int r);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s @rel %0d: got %h, expected %h", nm, r, act, expv);
        end
    endtask

    // responder programming: latency 0 = never answers
    int          lat    [NW];
    bit          errw   [NW];
    bit          errack [NW];
    logic [31:0] dat    [NW];
    int          resp_cyc = -1;
    int          resp_word = 0;

    always @(negedge clk_i) begin
        int w;
        if (rstn_i && bus_rden_o) begin
            w = int'((bus_addr_o - BASE) >> 2);
            if (w >= 0 && w < NW && lat[w] != 0) begin
                resp_word = w;
                resp_cyc  = cyc + lat[w];
            end
        end
    end

    always @(posedge clk_i) begin
        #1;
        bus_ack_i  = 1'b0;
        bus_err_i  = 1'b0;
        bus_data_i = 32'd0;
        if (cyc == resp_cyc) begin
            if (errw[resp_word]) begin
                bus_err_i  = 1'b1;
                bus_ack_i  = errack[resp_word];
                bus_data_i = 32'hBAD00000;
            end else begin
                bus_ack_i  = 1'b1;
                bus_data_i = dat[resp_word];
            end
        end
    end

    // model of one fetch, in cycles relative to the start cycle
    bit          exp_rden [MAXC];
    logic [31:0] exp_addr [MAXC];
    bit          exp_busy [MAXC];
    logic [31:0] prev_info [NW];
    logic [31:0] new_info  [NW];
    int          cap       [NW];
    int          m_done;
    bit          m_ok;
    logic [1:0]  m_code, prev_code;
    logic [2:0]  m_eidx, prev_eidx;
    bit          prev_valid;
    bit          chk = 1'b0;
    int          base = 0;

    task automatic build_model();
        int t;
        int r;
        bit fin;
        for (int i = 0; i < MAXC; i++) begin
            exp_rden[i] = 1'b0;
            exp_addr[i] = 32'd0;
            exp_busy[i] = 1'b0;
        end
        for (int k = 0; k < NW; k++) begin
            cap[k]      = -1;
            new_info[k] = prev_info[k];
        end
        t      = 1;
        fin    = 1'b0;
        m_ok   = 1'b0;
        m_code = 2'b00;
        m_eidx = prev_eidx;
        m_done = 0;
        for (int k = 0; k < NW && !fin; k++) begin
            exp_rden[t] = 1'b1;
            exp_addr[t] = BASE + 32'(4 * k);
            if (lat[k] != 0 && lat[k] <= TMO + 1) begin
                r = t + lat[k];
                if (errw[k]) begin
                    m_code = 2'b01;
                    m_eidx = 3'(k);
                    m_done = r + 1;
                    fin    = 1'b1;
                end else begin
                    cap[k]      = r + 1;
                    new_info[k] = dat[k];
                    if (k == NW - 1) begin
                        m_ok   = 1'b1;
                        m_done = r + 1;
                        fin    = 1'b1;
                    end else begin
                        t = r + 1;
                    end
                end
            end else begin
                m_code = 2'b10;
                m_eidx = 3'(k);
                m_done = t + TMO + 2;
                fin    = 1'b1;
            end
        end
        for (int i = 1; i < m_done; i++) exp_busy[i] = 1'b1;
    endtask

    always @(negedge clk_i) begin
        int r;
        logic [31:0] ew;
        if (chk) begin
            r = cyc - base;
            if (r >= 0 && r <= m_done + 1) begin
                check("rden", 32'(bus_rden_o), 32'(exp_rden[r]), r);
                check("addr", bus_addr_o, exp_addr[r], r);
                check("wren", 32'(bus_wren_o), 32'd0, r);
                check("busy", 32'(busy_o), 32'(exp_busy[r]), r);
                check("done", 32'(done_o), 32'(r == m_done), r);
                check("valid", 32'(valid_o),
                      32'((r >= m_done) ? m_ok : ((r == 0) ? prev_valid : 1'b0)), r);
                check("err_code", 32'(err_code_o),
                      32'((r >= m_done) ? m_code : ((r == 0) ? prev_code : 2'b00)), r);
                check("err_idx", 32'(err_idx_o),
                      32'((r >= m_done) ? m_eidx : prev_eidx), r);
                for (int k = 0; k < NW; k++) begin
                    ew = (cap[k] >= 0 && r >= cap[k]) ? new_info[k] : prev_info[k];
                    check($sformatf("info%0d", k), info_o[32*k +: 32], ew, r);
                end
            end
        end
    end

    task automatic set_resp(input int l, input logic [31:0] pat);
        for (int k = 0; k < NW; k++) begin
            lat[k]    = l;
            errw[k]   = 1'b0;
            errack[k] = 1'b0;
            dat[k]    = pat + 32'(k);
        end
    endtask

    // must be entered just after a rising edge; leaves just after one
    task automatic run_fetch(input bit via_reset, input int extra_start);
        build_model();
        base = cyc;
        if (via_reset) rstn_i = 1'b1;
        else           start_i = 1'b1;
        chk = 1'b1;
        while (cyc - base < m_done + 2) begin
            @(posedge clk_i);
            #1;
            start_i = (extra_start >= 0) && (cyc - base == extra_start);
        end
        start_i = 1'b0;
        chk     = 1'b0;
        for (int k = 0; k < NW; k++) prev_info[k] = new_info[k];
        prev_valid = m_ok;
        prev_code  = m_code;
        prev_eidx  = m_eidx;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rden"}, 32'(bus_rden_o), 32'd0, -1);
        check({tag, "_addr"}, bus_addr_o, 32'd0, -1);
        check({tag, "_wren"}, 32'(bus_wren_o), 32'd0, -1);
        check({tag, "_busy"}, 32'(busy_o), 32'd0, -1);
        check({tag, "_done"}, 32'(done_o), 32'd0, -1);
        check({tag, "_valid"}, 32'(valid_o), 32'd0, -1);
        check({tag, "_code"}, 32'(err_code_o), 32'd0, -1);
        check({tag, "_eidx"}, 32'(err_idx_o), 32'd0, -1);
        for (int k = 0; k < NW; k++)
            check($sformatf("%s_info%0d", tag, k), info_o[32*k +: 32], 32'd0, -1);
    endtask

    task automatic clear_prev();
        for (int k = 0; k < NW; k++) prev_info[k] = 32'd0;
        prev_valid = 1'b0;
        prev_code  = 2'b00;
        prev_eidx  = 3'd0;
    endtask

    initial begin
        clear_prev();
        set_resp(1, 32'h11110000);
        #2;
        check_reset_vals("por");
        gap(3);

        // power-on auto-start
        run_fetch(1'b1, -1);
        gap(3);

        // nominal fetch
        set_resp(1, 32'hA0000000);
        run_fetch(1'b0, -1);
        check("pin_nom_done", 32'(m_done), 32'd17, -1);
        check("pin_nom_rden15", 32'(exp_rden[15]), 32'd1, -1);
        check("pin_nom_addr15", exp_addr[15], 32'hFFFFFFFC, -1);
        check("nom_word3", info_o[127:96], 32'hA0000003, -1);
        check("nom_valid", 32'(valid_o), 32'd1, -1);
        gap(3);

        // slow responder
        set_resp(3, 32'hB0000000);
        run_fetch(1'b0, -1);
        check("pin_slow_done", 32'(m_done), 32'd33, -1);
        gap(3);

        // bus error at word 5
        set_resp(1, 32'hC0000000);
        errw[5] = 1'b1;
        run_fetch(1'b0, -1);
        check("buserr_code", 32'(err_code_o), 32'd1, -1);
        check("buserr_idx", 32'(err_idx_o), 32'd5, -1);
        check("buserr_w4", info_o[159:128], 32'hC0000004, -1);
        check("buserr_w5", info_o[191:160], 32'hB0000005, -1);
        gap(3);

        // error and ack together at word 5
        set_resp(1, 32'hD0000000);
        errw[5]   = 1'b1;
        errack[5] = 1'b1;
        run_fetch(1'b0, -1);
        check("errack_code", 32'(err_code_o), 32'd1, -1);
        check("errack_w5", info_o[191:160], 32'hB0000005, -1);
        gap(3);

        // timeout on word 2
        set_resp(1, 32'hE0000000);
        lat[2] = 0;
        run_fetch(1'b0, -1);
        check("pin_tmo_done", 32'(m_done), 32'd22, -1);
        check("tmo_code", 32'(err_code_o), 32'd2, -1);
        check("tmo_idx", 32'(err_idx_o), 32'd2, -1);
        check("tmo_valid", 32'(valid_o), 32'd0, -1);
        gap(20);

        // ack in the last tolerated WAIT cycle
        set_resp(1, 32'hF0000000);
        lat[2] = 16;
        run_fetch(1'b0, -1);
        check("pin_late_done", 32'(m_done), 32'd32, -1);
        check("late_w2", info_o[95:64], 32'hF0000002, -1);
        gap(3);

        // start while busy
        set_resp(1, 32'h12340000);
        run_fetch(1'b0, 4);
        check("busy_start_valid", 32'(valid_o), 32'd1, -1);
        gap(3);

        // reset in the middle of a fetch
        set_resp(1, 32'h55550000);
        start_i = 1'b1;
        gap(1);
        start_i = 1'b0;
        gap(5);
        rstn_i = 1'b0;
        #1;
        check_reset_vals("midrst");
        gap(2);
        clear_prev();
        set_resp(1, 32'h66660000);
        run_fetch(1'b1, -1);
        check("postrst_word7", info_o[255:224], 32'h66660007, -1);
        gap(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
